// File: rtl/ntt_mr_addr_if.sv
// Handshake and tuple/strobe bundle between the NTT controller and the
// mixed-radix address sequencer.
interface ntt_mr_addr_if #(
    parameter int unsigned LOG_N = 6,
    parameter int unsigned PW    = $clog2(LOG_N)
);
    logic             start;
    logic             mode;
    logic             hold;
    logic             busy;
    logic             sel;
    logic [PW-1:0]    p;
    logic [LOG_N-1:0] k;
    logic [LOG_N-1:0] j;
    logic             issue;
    logic             iren;
    logic             ien;
    logic             iwen;
    logic [1:0]       done;
    logic             err;

    modport master (
        output start, mode, hold,
        input  busy, sel, p, k, j, issue, iren, ien, iwen, done, err
    );

    modport slave (
        input  start, mode, hold,
        output busy, sel, p, k, j, issue, iren, ien, iwen, done, err
    );
endinterface

// File: rtl/ntt_mr_addr_fsm.sv
// Mixed-radix (2/4) NTT sequencer: walks every (stage, block, butterfly)
// tuple and emits read/enable/write strobes aligned to the butterfly latency.
module ntt_mr_addr_fsm #(
    parameter int unsigned LOG_N  = 6,
    parameter int unsigned LAT_R2 = 8,
    parameter int unsigned LAT_R4 = 14,
    parameter int unsigned PW     = $clog2(LOG_N)
) (
    input  logic         clk,
    input  logic         rst,
    ntt_mr_addr_if.slave bus
);
    localparam int unsigned LAT_MAX   = (LAT_R2 > LAT_R4) ? LAT_R2 : LAT_R4;
    localparam int unsigned CW        = $clog2(LAT_MAX + 1);
    localparam bit          LOG_N_ODD = (LOG_N % 2) == 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic               sel;
    logic [PW-1:0]      p;
    logic [LOG_N-1:0]   k;
    logic [LOG_N-1:0]   j;
    logic [CW-1:0]      cnt;
    logic [LAT_MAX-1:0] dly;
    logic               busy;
    logic [1:0]         done;
    logic               err;
    logic               issue;
    logic [31:0]        j_sh;
    logic [31:0]        k_sh;
    logic [LOG_N-1:0]   j_max;
    logic [LOG_N-1:0]   k_max;
    logic [CW-1:0]      lat_m1;

    assign issue  = (state == RUN) && !bus.hold;
    assign lat_m1 = sel ? CW'(LAT_R4 - 1) : CW'(LAT_R2 - 1);

    // Loop bounds: radix-2 uses 2^p butterflies per block, radix-4 uses 4^p.
    always_comb begin
        j_sh  = sel ? (32'(p) << 1) : 32'(p);
        k_sh  = 32'(LOG_N) - (sel ? 32'd2 : 32'd1) - j_sh;
        j_max = LOG_N'((32'd1 << j_sh) - 32'd1);
        k_max = LOG_N'((32'd1 << k_sh) - 32'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            p     <= '0;
            k     <= '0;
            j     <= '0;
            cnt   <= '0;
            dly   <= '0;
            busy  <= 1'b0;
            done  <= 2'b00;
            err   <= 1'b0;
        end else begin
            dly  <= {dly[LAT_MAX-2:0], issue};
            done <= 2'b00;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mode && LOG_N_ODD) begin
                            err <= 1'b1;
                        end else begin
                            // Previous pass is fully drained; clearing keeps
                            // leftover taps of the other radix from leaking.
                            state <= RUN;
                            busy  <= 1'b1;
                            sel   <= bus.mode;
                            p     <= bus.mode ? PW'(LOG_N / 2 - 1) : PW'(LOG_N - 1);
                            k     <= '0;
                            j     <= '0;
                            dly   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (j != j_max) begin
                            j <= j + LOG_N'(1);
                        end else begin
                            j <= '0;
                            if (k != k_max) begin
                                k <= k + LOG_N'(1);
                            end else begin
                                k <= '0;
                                if (p != '0) begin
                                    p <= p - PW'(1);
                                end else begin
                                    state <= DRAIN;
                                    cnt   <= lat_m1;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= sel ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.sel   = sel;
    assign bus.p     = p;
    assign bus.k     = k;
    assign bus.j     = j;
    assign bus.issue = issue;
    assign bus.iren  = dly[0];
    assign bus.ien   = sel ? dly[LAT_R4-2] : dly[LAT_R2-2];
    assign bus.iwen  = sel ? dly[LAT_R4-1] : dly[LAT_R2-1];
    assign bus.done  = done;
    assign bus.err   = err;
endmodule

// File: tb/tb_ntt_mr_addr_fsm.sv
// Randomized bench for ntt_mr_addr_fsm: expected timelines are derived from
// the tuple list and per-cycle hold pattern using plain arithmetic.
module tb_ntt_mr_addr_fsm;
    localparam int unsigned LAT_R2 = 8;
    localparam int unsigned LAT_R4 = 14;
    localparam int          MAXC   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_v = 1'b0;
    logic mode_v  = 1'b0;
    logic hold_v  = 1'b0;
    logic dsel    = 1'b0;

    int errors = 0;
    int checks = 0;

    bit hold_q [MAXC];
    bit ex_iss [MAXC];
    int tix    [MAXC];

    logic [31:0] o_busy, o_sel, o_issue, o_iren, o_ien, o_iwen, o_done, o_err, o_tup;

    ntt_mr_addr_if #(.LOG_N(6)) b6 ();
    ntt_mr_addr_if #(.LOG_N(5)) b5 ();

    ntt_mr_addr_fsm #(.LOG_N(6), .LAT_R2(LAT_R2), .LAT_R4(LAT_R4)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (b6)
    );

    ntt_mr_addr_fsm #(.LOG_N(5), .LAT_R2(LAT_R2), .LAT_R4(LAT_R4)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (b5)
    );

    assign b6.start = start_v & ~dsel;
    assign b6.mode  = mode_v;
    assign b6.hold  = hold_v;
    assign b5.start = start_v & dsel;
    assign b5.mode  = mode_v;
    assign b5.hold  = hold_v;

    always #5 clk = ~clk;

    always_comb begin
        if (dsel) begin
            o_busy  = 32'(b5.busy);
            o_sel   = 32'(b5.sel);
            o_issue = 32'(b5.issue);
            o_iren  = 32'(b5.iren);
            o_ien   = 32'(b5.ien);
            o_iwen  = 32'(b5.iwen);
            o_done  = 32'(b5.done);
            o_err   = 32'(b5.err);
            o_tup   = (32'(b5.p) << 16) | (32'(b5.k) << 8) | 32'(b5.j);
        end else begin
            o_busy  = 32'(b6.busy);
            o_sel   = 32'(b6.sel);
            o_issue = 32'(b6.issue);
            o_iren  = 32'(b6.iren);
            o_ien   = 32'(b6.ien);
            o_iwen  = 32'(b6.iwen);
            o_done  = 32'(b6.done);
            o_err   = 32'(b6.err);
            o_tup   = (32'(b6.p) << 16) | (32'(b6.k) << 8) | 32'(b6.j);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ex_at(input int c);
        return (c >= 0 && c < MAXC) ? ex_iss[c] : 1'b0;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_sel"},   o_sel,   0);
        check({tag, "_issue"}, o_issue, 0);
        check({tag, "_iren"},  o_iren,  0);
        check({tag, "_ien"},   o_ien,   0);
        check({tag, "_iwen"},  o_iwen,  0);
        check({tag, "_done"},  o_done,  0);
        check({tag, "_err"},   o_err,   0);
        check({tag, "_tuple"}, o_tup,   0);
    endtask

    // hmode: 0 no hold, 1 hold over cycles 10..14, 2 random hold.
    task automatic run_pass(input bit d5, input bit md, input int hmode,
                            input bit disturb, input int abort_at);
        int tq[$];
        int log_n, lat, total, n, last_c, c_done, ncyc;
        log_n = d5 ? 5 : 6;
        lat   = md ? int'(LAT_R4) : int'(LAT_R2);
        if (md) begin
            for (int s = log_n / 2 - 1; s >= 0; s--)
                for (int kk = 0; kk < (1 << (log_n - 2 * s - 2)); kk++)
                    for (int jj = 0; jj < (1 << (2 * s)); jj++)
                        tq.push_back((s << 16) | (kk << 8) | jj);
        end else begin
            for (int s = log_n - 1; s >= 0; s--)
                for (int kk = 0; kk < (1 << (log_n - s - 1)); kk++)
                    for (int jj = 0; jj < (1 << s); jj++)
                        tq.push_back((s << 16) | (kk << 8) | jj);
        end
        total  = tq.size();
        n      = 0;
        last_c = 0;
        for (int c = 0; c < MAXC; c++) begin
            case (hmode)
                1:       hold_q[c] = (c >= 10 && c <= 14);
                2:       hold_q[c] = (c < 600) && ($urandom_range(0, 3) == 0);
                default: hold_q[c] = 1'b0;
            endcase
            ex_iss[c] = (c >= 1) && (n < total) && !hold_q[c];
            tix[c]    = n;
            if (ex_iss[c]) begin
                n++;
                last_c = c;
            end
        end
        c_done = last_c + lat + 1;
        ncyc   = c_done + 3;
        dsel   = d5;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start_v = (c == 0) || (disturb && c <= c_done && $urandom_range(0, 7) == 0);
            mode_v  = (c == 0 || !disturb) ? md : 1'($urandom_range(0, 1));
            hold_v  = hold_q[c];
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                check_zero($sformatf("abort@%0d", c));
                @(negedge clk);
                rst     = 1'b1;
                start_v = 1'b0;
                hold_v  = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check($sformatf("post_abort_iwen@%0d", i), o_iwen, 0);
                    check($sformatf("post_abort_done@%0d", i), o_done, 0);
                    check($sformatf("post_abort_busy@%0d", i), o_busy, 0);
                end
                return;
            end
            @(negedge clk);
            check($sformatf("issue@%0d", c), o_issue, 32'(ex_iss[c]));
            check($sformatf("iren@%0d", c),  o_iren,  32'(ex_at(c - 1)));
            check($sformatf("ien@%0d", c),   o_ien,   32'(ex_at(c - lat + 1)));
            check($sformatf("iwen@%0d", c),  o_iwen,  32'(ex_at(c - lat)));
            check($sformatf("busy@%0d", c),  o_busy,  32'(c >= 1 && c <= c_done));
            check($sformatf("done@%0d", c),  o_done,  (c == c_done) ? (md ? 32'd2 : 32'd1) : 32'd0);
            check($sformatf("err@%0d", c),   o_err,   0);
            if (c >= 1 && c <= c_done)
                check($sformatf("sel@%0d", c), o_sel, 32'(md));
            if (ex_iss[c])
                check($sformatf("tuple@%0d", c), o_tup, 32'(tq[tix[c]]));
        end
        start_v = 1'b0;
        hold_v  = 1'b0;
    endtask

    task automatic reject_pass();
        dsel = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            start_v = (c == 0);
            mode_v  = 1'b1;
            hold_v  = 1'b0;
            @(negedge clk);
            check($sformatf("rej_err@%0d", c),   o_err,   32'(c == 1));
            check($sformatf("rej_busy@%0d", c),  o_busy,  0);
            check($sformatf("rej_issue@%0d", c), o_issue, 0);
            check($sformatf("rej_done@%0d", c),  o_done,  0);
        end
        start_v = 1'b0;
        mode_v  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset6");
        dsel = 1'b1;
        #1;
        check_zero("reset5");
        dsel = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_pass(1'b0, 1'b0, 0, 1'b0, -1);
        run_pass(1'b0, 1'b1, 0, 1'b0, -1);
        reject_pass();
        run_pass(1'b1, 1'b0, 0, 1'b0, -1);
        run_pass(1'b0, 1'b1, 1, 1'b0, -1);
        run_pass(1'b0, 1'b0, 0, 1'b0, 196);
        run_pass(1'b0, 1'b0, 0, 1'b0, -1);
        run_pass(1'b0, 1'b1, 0, 1'b1, -1);
        run_pass(1'b0, 1'b0, 0, 1'b1, -1);
        for (int i = 0; i < 4; i++)
            run_pass(1'b0, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), -1);
        run_pass(1'b1, 1'b0, 2, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
